// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor: counter encodings, BTB entry layout
// and the init/run controller states.
package branch_pkg;

  localparam int unsigned BP_WIDTH = 31;
  localparam int unsigned BP_IDX   = 6;
  localparam int unsigned BP_TAG_W = BP_WIDTH - BP_IDX - 1;

  localparam logic [1:0] STATE_ST  = 2'b11;
  localparam logic [1:0] STATE_WT  = 2'b10;
  localparam logic [1:0] STATE_WNT = 2'b01;
  localparam logic [1:0] STATE_SNT = 2'b00;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_WIDTH:0]   target;
  } btb_entry_t;

  typedef enum logic {INIT, RUN} bp_state_t;

endpackage

// File: rtl/btb_array.sv
// Branch target buffer storage: one combinational read port, one write port that either
// writes a whole entry or clears valid when the stored tag matches; write-first forwarding.
module btb_array
  import branch_pkg::*;
#(
  parameter int unsigned IDX = BP_IDX
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic           inval_i,
  input  logic [IDX-1:0] waddr_i,
  input  btb_entry_t     wdata_i,
  input  logic [IDX-1:0] raddr_i,
  output btb_entry_t     rdata_o
);

  localparam int unsigned Entries = 2 ** IDX;

  btb_entry_t mem_q [Entries];
  btb_entry_t cur_entry;
  btb_entry_t wr_next;

  // Conditional invalidate is a read-modify-write of the addressed entry.
  always_comb begin
    cur_entry = mem_q[waddr_i];
    wr_next   = wdata_i;
    if (inval_i) begin
      wr_next = cur_entry;
      if (cur_entry.tag == wdata_i.tag) wr_next.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wr_next;
  end

  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) rdata_o = wr_next;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: BTB plus 2-bit PHT, an init sweep after reset, and registered
// lookup outputs with write-first forwarding from the commit-side update.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = BP_WIDTH,
  parameter int unsigned IDX   = BP_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookupValid,
  input  logic [WIDTH:0]   fetchPC,
  output logic [WIDTH:0]   predictedPC,
  output logic             redirect,
  output logic [1:0]       state,
  output logic             ready,
  input  logic             updateValid,
  input  logic [WIDTH:0]   updatePC,
  input  logic             updateTaken,
  input  logic             writeBTB,
  input  logic [WIDTH:0]   correctAddress,
  input  logic [1:0]       updateNextState
);

  localparam int unsigned Entries = 2 ** IDX;

  bp_state_t      st_q, st_d;
  logic [IDX-1:0] cnt_q, cnt_d;
  logic           in_init;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= INIT;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (st_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) st_d = RUN;
    end
  end

  assign in_init = (st_q == INIT);
  assign ready   = (st_q == RUN);

  logic [IDX-1:0]         lk_idx, up_idx;
  logic [WIDTH-IDX-2:0]   lk_tag, up_tag;
  logic                   unused_pc_bits;

  assign lk_idx         = fetchPC[IDX+1:2];
  assign lk_tag         = fetchPC[WIDTH:IDX+2];
  assign up_idx         = updatePC[IDX+1:2];
  assign up_tag         = updatePC[WIDTH:IDX+2];
  assign unused_pc_bits = ^updatePC[1:0];

  // The init sweep owns both write ports; commit updates are dropped until RUN.
  logic           btb_we, btb_inval;
  logic [IDX-1:0] wr_idx;
  btb_entry_t     btb_wdata, btb_rdata;

  assign wr_idx    = in_init ? cnt_q : up_idx;
  assign btb_we    = in_init | (updateValid & writeBTB);
  assign btb_inval = ~in_init & ~updateTaken;

  always_comb begin
    btb_wdata = '0;
    if (!in_init) btb_wdata = '{valid: 1'b1, tag: up_tag, target: correctAddress};
  end

  btb_array #(
    .IDX (IDX)
  ) u_btb (
    .clk_i   (clk),
    .we_i    (btb_we),
    .inval_i (btb_inval),
    .waddr_i (wr_idx),
    .wdata_i (btb_wdata),
    .raddr_i (lk_idx),
    .rdata_o (btb_rdata)
  );

  logic [1:0] pht_q [Entries];
  logic       pht_we;
  logic [1:0] pht_wdata, pht_rd;

  assign pht_we    = in_init | updateValid;
  assign pht_wdata = in_init ? STATE_WNT : updateNextState;

  always_ff @(posedge clk) begin
    if (pht_we) pht_q[wr_idx] <= pht_wdata;
  end

  assign pht_rd = (pht_we && (wr_idx == lk_idx)) ? pht_wdata : pht_q[lk_idx];

  logic [WIDTH:0] pred_q, pred_d, seq_pc;
  logic           redir_q, redir_d, hit;
  logic [1:0]     state_q, state_d;

  assign seq_pc = fetchPC + (WIDTH+1)'(4);
  assign hit    = btb_rdata.valid && (btb_rdata.tag == lk_tag);

  always_comb begin
    pred_d  = pred_q;
    redir_d = redir_q;
    state_d = state_q;
    if (lookupValid) begin
      if (in_init) begin
        pred_d  = seq_pc;
        redir_d = 1'b0;
        state_d = STATE_WNT;
      end else begin
        redir_d = hit & pht_rd[1];
        pred_d  = (hit & pht_rd[1]) ? btb_rdata.target : seq_pc;
        state_d = pht_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_q  <= '0;
      redir_q <= 1'b0;
      state_q <= STATE_WNT;
    end else begin
      pred_q  <= pred_d;
      redir_q <= redir_d;
      state_q <= state_d;
    end
  end

  assign predictedPC = pred_q;
  assign redirect    = redir_q;
  assign state       = state_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against an index/tag table model, with directed
// scenarios for init timing, insert, alias, invalidate, collision, reset and PC wrap.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookupValid;
  logic [31:0] fetchPC;
  logic [31:0] predictedPC;
  logic        redirect;
  logic [1:0]  state;
  logic        ready;
  logic        updateValid;
  logic [31:0] updatePC;
  logic        updateTaken;
  logic        writeBTB;
  logic [31:0] correctAddress;
  logic [1:0]  updateNextState;

  always #5 clk = ~clk;

  branch_predictor u_dut (
    .clk             (clk),
    .reset           (reset),
    .lookupValid     (lookupValid),
    .fetchPC         (fetchPC),
    .predictedPC     (predictedPC),
    .redirect        (redirect),
    .state           (state),
    .ready           (ready),
    .updateValid     (updateValid),
    .updatePC        (updatePC),
    .updateTaken     (updateTaken),
    .writeBTB        (writeBTB),
    .correctAddress  (correctAddress),
    .updateNextState (updateNextState)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 64 entries keyed by PC[7:2], tag PC[31:8].
  bit        m_valid [64];
  bit [23:0] m_tag   [64];
  bit [31:0] m_tgt   [64];
  bit [1:0]  m_pht   [64];
  int        init_left = 64;
  bit [31:0] e_pred  = 0;
  bit        e_redir = 0;
  bit [1:0]  e_state = 2'b01;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit lv, input bit [31:0] fpc, input bit uv,
                            input bit [31:0] upc, input bit ut, input bit wb,
                            input bit [31:0] ca, input bit [1:0] ns);
    int i;
    if (rst) begin
      init_left = 64;
      e_pred    = 0;
      e_redir   = 0;
      e_state   = 2'b01;
    end else if (init_left > 0) begin
      i = 64 - init_left;
      m_valid[i] = 0;
      m_pht[i]   = 2'b01;
      init_left--;
      if (lv) begin
        e_pred  = fpc + 32'd4;
        e_redir = 0;
        e_state = 2'b01;
      end
    end else begin
      if (uv) begin
        i = int'(upc[7:2]);
        m_pht[i] = ns;
        if (wb && ut) begin
          m_valid[i] = 1;
          m_tag[i]   = upc[31:8];
          m_tgt[i]   = ca;
        end else if (wb && m_tag[i] == upc[31:8]) begin
          m_valid[i] = 0;
        end
      end
      if (lv) begin
        i = int'(fpc[7:2]);
        e_state = m_pht[i];
        e_redir = m_valid[i] && (m_tag[i] == fpc[31:8]) && m_pht[i][1];
        e_pred  = e_redir ? m_tgt[i] : fpc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit rst, input bit lv, input bit [31:0] fpc, input bit uv,
                      input bit [31:0] upc, input bit ut, input bit wb, input bit [31:0] ca,
                      input bit [1:0] ns);
    reset           = rst;
    lookupValid     = lv;
    fetchPC         = fpc;
    updateValid     = uv;
    updatePC        = upc;
    updateTaken     = ut;
    writeBTB        = wb;
    correctAddress  = ca;
    updateNextState = ns;
    @(posedge clk);
    model_edge(rst, lv, fpc, uv, upc, ut, wb, ca, ns);
    #1;
    check_val("predictedPC", predictedPC, e_pred);
    check_val("redirect", {31'd0, redirect}, {31'd0, e_redir});
    check_val("state", {30'd0, state}, {30'd0, e_state});
    check_val("ready", {31'd0, ready}, {31'd0, init_left == 0});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input bit [31:0] pc);
    step(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input bit [31:0] pc, input bit t, input bit wb, input bit [31:0] ca,
                        input bit [1:0] ns);
    step(0, 0, 0, 1, pc, t, wb, ca, ns);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("rst_pred", predictedPC, 32'h0);
    check_val("rst_state", {30'd0, state}, 32'd1);
  endtask

  initial begin
    bit [31:0] pc_a, pc_b;

    do_reset();
    // Init window: ready low for 64 cycles, high on the 65th.
    for (int k = 0; k < 63; k++) begin
      if (k == 10) lookup(32'h0000_0040);
      else idle();
      if (k == 10) begin
        check_val("init_redirect", {31'd0, redirect}, 32'd0);
        check_val("init_state", {30'd0, state}, 32'd1);
      end
    end
    check_val("init_ready_low", {31'd0, ready}, 32'd0);
    idle();
    check_val("init_ready_high", {31'd0, ready}, 32'd1);

    update(32'h0000_0040, 1, 1, 32'h0000_0100, 2'b10);
    lookup(32'h0000_0040);
    check_val("ins_pred", predictedPC, 32'h0000_0100);
    check_val("ins_redirect", {31'd0, redirect}, 32'd1);
    check_val("ins_state", {30'd0, state}, 32'd2);

    lookup(32'h0000_1040);
    check_val("alias_pred", predictedPC, 32'h0000_1044);
    check_val("alias_redirect", {31'd0, redirect}, 32'd0);

    update(32'h0000_0040, 0, 1, 32'h0, 2'b01);
    lookup(32'h0000_0040);
    check_val("inval_pred", predictedPC, 32'h0000_0044);
    check_val("inval_state", {30'd0, state}, 32'd1);

    update(32'h0000_0040, 1, 1, 32'h0000_0100, 2'b10);
    update(32'h0000_1040, 0, 1, 32'h0, 2'b10);
    lookup(32'h0000_0040);
    check_val("keep_pred", predictedPC, 32'h0000_0100);

    step(0, 1, 32'h0000_0080, 1, 32'h0000_0080, 1, 1, 32'h0000_0200, 2'b11);
    check_val("coll_pred", predictedPC, 32'h0000_0200);
    check_val("coll_redirect", {31'd0, redirect}, 32'd1);
    check_val("coll_state", {30'd0, state}, 32'd3);

    update(32'h0000_0040, 1, 1, 32'h0000_0100, 2'b10);
    do_reset();
    for (int k = 0; k < 64; k++) idle();
    lookup(32'h0000_0040);
    check_val("rerst_redirect", {31'd0, redirect}, 32'd0);
    check_val("rerst_state", {30'd0, state}, 32'd1);
    lookup(32'hFFFF_FFFC);
    check_val("wrap_pred", predictedPC, 32'h0000_0000);

    // Random traffic over a few tags and indices so hits, aliases and collisions recur.
    for (int k = 0; k < 3000; k++) begin
      pc_a = {22'($urandom_range(0, 2)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      pc_b = ($urandom_range(0, 3) == 0) ? pc_a :
             {22'($urandom_range(0, 2)), 3'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 15) == 0) pc_b = $urandom;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step(0, 1'($urandom), pc_b, 1'($urandom), pc_a, 1'($urandom), 1'($urandom),
             $urandom, 2'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
